dsp_exmem_pipe: RTL

- Pipeline register and issue controller between the execute stage (ALU) and the DSP memory-logic stage.
- Latches one operation per transfer and drives the memory stage's mem_mode, data_s1, data_s2, alu_result and write_back_en inputs.
- Stretches loads to two cycles to cover the synchronous SRAM read latency, and inserts bubbles (MEM_NONE, no write-back) whenever no operation is completing.
- Back-pressures the execute stage and counts stall cycles.

---
 rtl/dsp_exmem_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dsp_exmem_pipe.sv
// Execute-to-memory pipeline register and issue controller for the DSP core.
// Holds one operation at a time. Loads are stretched over an address cycle and
// a data cycle to cover the synchronous SRAM read. The memory stage only sees
// a real mem_mode and write-back in the cycle the occupant completes.
//
// Memory mode codes shared with the memory stage:
//   0 = MEM_NONE, 1 = MEM_LD, 2 = MEM_ST, 3 = MEM_LD_IMM.
// Any other code is passed through as a non-load.
module dsp_exmem_pipe #(
    parameter int DATA_W = 16,
    parameter int MODE_W = 3,
    parameter int DST_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [MODE_W-1:0] ex_mem_mode,
    input  logic [DATA_W-1:0] ex_data_s1,
    input  logic [DATA_W-1:0] ex_data_s2,
    input  logic              ex_write_back_en,
    input  logic [DST_W-1:0]  ex_dst,
    input  logic              mem_stall,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_result,
    output logic [MODE_W-1:0] mem_mode,
    output logic [DATA_W-1:0] data_s1,
    output logic [DATA_W-1:0] data_s2,
    output logic              write_back_en,
    output logic [DST_W-1:0]  wb_dst,
    output logic              busy_ld,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [MODE_W-1:0] MEM_NONE = MODE_W'(0);
    localparam logic [MODE_W-1:0] MEM_LD   = MODE_W'(1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ISSUE,
        S_LD_ADDR,
        S_LD_DATA
    } state_t;

    state_t state, state_nxt;

    logic              completing;
    logic              accept;
    state_t            accept_state;

    logic [MODE_W-1:0] mode_p0;
    logic              wb_en_p0;
    logic [DATA_W-1:0] alu_p0;
    logic [DATA_W-1:0] s1_p0;
    logic [DATA_W-1:0] s2_p0;
    logic [DST_W-1:0]  dst_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A load's data cycle completes regardless of mem_stall: the read already happened.
    assign completing   = (state == S_ISSUE && !mem_stall) || (state == S_LD_DATA);
    assign ex_ready     = rst_n && !flush && ((state == S_EMPTY) || completing);
    assign accept       = ex_valid && ex_ready;
    assign accept_state = (ex_mem_mode == MEM_LD) ? S_LD_ADDR : S_ISSUE;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    // Next-state logic; flush empties the slot and blocks any accept.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY:   state_nxt = accept ? accept_state : S_EMPTY;
                S_ISSUE:   if (!mem_stall) state_nxt = accept ? accept_state : S_EMPTY;
                S_LD_ADDR: if (!mem_stall) state_nxt = S_LD_DATA;
                S_LD_DATA: state_nxt = accept ? accept_state : S_EMPTY;
                default:   state_nxt = S_EMPTY;
            endcase
        end
    end

    // ---- stage p0: operation latched on accept ----
    // Capture all execute-stage fields; they are held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_p0  <= MEM_NONE;
            wb_en_p0 <= 1'b0;
            alu_p0   <= '0;
            s1_p0    <= '0;
            s2_p0    <= '0;
            dst_p0   <= '0;
        end else if (accept) begin
            mode_p0  <= ex_mem_mode;
            wb_en_p0 <= ex_write_back_en;
            alu_p0   <= ex_alu_result;
            s1_p0    <= ex_data_s1;
            s2_p0    <= ex_data_s2;
            dst_p0   <= ex_dst;
        end
    end

    // Count cycles in which the execute stage is held off, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    stall_count <= '0;
        else if (ex_valid && !ex_ready) stall_count <= sat_inc(stall_count);
    end

    // Side-effecting outputs are only live in the completing cycle, and never under flush.
    assign mem_mode      = (completing && !flush) ? mode_p0 : MEM_NONE;
    assign write_back_en = completing && !flush && wb_en_p0;
    assign busy_ld       = (state == S_LD_ADDR);
    assign alu_result    = alu_p0;
    assign data_s1       = s1_p0;
    assign data_s2       = s2_p0;
    assign wb_dst        = dst_p0;

endmodule
